// File: rtl/mining_sequencer.sv
// Control sequencer for the hash-mining datapath: loads message words, then walks a
// nonce range running ROUNDS x ROUND_CYCLES compression sub-phases plus a target check
// per nonce, stopping on a hit, on range exhaustion or on abort.
module mining_sequencer #(
  parameter  int unsigned NONCE_W      = 32,
  parameter  int unsigned ROUNDS       = 64,
  parameter  int unsigned ROUND_CYCLES = 3,
  parameter  int unsigned LOAD_WORDS   = 16,
  localparam int unsigned RIDX_W       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               word_valid,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] nonce_limit,
  input  logic               hash_hit,
  output logic [2:0]         state,
  output logic               load_ready,
  output logic               round_en,
  output logic [RIDX_W-1:0]  round_idx,
  output logic [1:0]         phase,
  output logic [NONCE_W-1:0] nonce,
  output logic               done,
  output logic               found
);

  localparam int unsigned WCNT_W = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PREP    = 3'd2,
    S_ROUND   = 3'd3,
    S_CHECK   = 3'd4,
    S_NEXT    = 3'd5,
    S_FOUND   = 3'd6,
    S_EXHAUST = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [RIDX_W-1:0]   round_idx_q, round_idx_d;
  logic [1:0]          phase_q, phase_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [NONCE_W-1:0]  limit_q, limit_d;

  // State and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      round_idx_q <= '0;
      phase_q     <= '0;
      nonce_q     <= '0;
      limit_q     <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      round_idx_q <= round_idx_d;
      phase_q     <= phase_d;
      nonce_q     <= nonce_d;
      limit_q     <= limit_d;
    end
  end

  // Next-state and counter update; abort overrides everything but reset
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    round_idx_d = round_idx_q;
    phase_d     = phase_q;
    nonce_d     = nonce_q;
    limit_d     = limit_q;

    if (abort) begin
      state_d     = S_IDLE;
      word_cnt_d  = '0;
      round_idx_d = '0;
      phase_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_FOUND, S_EXHAUST: begin
          if (start) begin
            state_d    = S_LOAD;
            nonce_d    = nonce_base;
            limit_d    = nonce_limit;
            word_cnt_d = '0;
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            word_cnt_d = word_cnt_q + WCNT_W'(1);
            if (word_cnt_q == WCNT_W'(LOAD_WORDS - 1)) state_d = S_PREP;
          end
        end
        S_PREP: begin
          round_idx_d = '0;
          phase_d     = '0;
          state_d     = S_ROUND;
        end
        S_ROUND: begin
          if (phase_q == 2'(ROUND_CYCLES - 1)) begin
            phase_d = '0;
            if (round_idx_q == RIDX_W'(ROUNDS - 1)) state_d = S_CHECK;
            else round_idx_d = round_idx_q + RIDX_W'(1);
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
        S_CHECK: begin
          if (hash_hit)               state_d = S_FOUND;
          else if (nonce_q == limit_q) state_d = S_EXHAUST;
          else                         state_d = S_NEXT;
        end
        S_NEXT: begin
          nonce_d = nonce_q + NONCE_W'(1);
          state_d = S_PREP;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registers or decodes of the registered state
  assign state      = state_q;
  assign load_ready = (state_q == S_LOAD);
  assign round_en   = (state_q == S_ROUND);
  assign round_idx  = round_idx_q;
  assign phase      = phase_q;
  assign nonce      = nonce_q;
  assign done       = (state_q == S_FOUND) || (state_q == S_EXHAUST);
  assign found      = (state_q == S_FOUND);

endmodule

// File: tb/tb_mining_sequencer.sv
// Scoreboard bench for mining_sequencer: each job is expanded into a cycle-by-cycle
// expected trace from the job-level rules, driven with random noise, and checked by a
// separate monitor.
module tb_mining_sequencer;

  localparam int NW = 5;
  localparam int NR = 4;
  localparam int RC = 3;
  localparam int LW = 2;
  localparam int NMOD = 32;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_PREP = 3'd2, S_ROUND = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4, S_NEXT = 3'd5, S_FOUND = 3'd6, S_EXHAUST = 3'd7;

  logic          clock = 1'b0;
  logic          reset, start, abort, word_valid, hash_hit;
  logic [NW-1:0] nonce_base, nonce_limit;
  logic [2:0]    state;
  logic          load_ready, round_en, done, found;
  logic [1:0]    round_idx;
  logic [1:0]    phase;
  logic [NW-1:0] nonce;

  mining_sequencer #(.NONCE_W(NW), .ROUNDS(NR), .ROUND_CYCLES(RC), .LOAD_WORDS(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .word_valid(word_valid),
    .nonce_base(nonce_base), .nonce_limit(nonce_limit), .hash_hit(hash_hit),
    .state(state), .load_ready(load_ready), .round_en(round_en), .round_idx(round_idx),
    .phase(phase), .nonce(nonce), .done(done), .found(found)
  );

  always #5 clock = ~clock;

  typedef struct { logic [2:0] st; int nonce; int ridx; int ph; bit chk_rp; } exp_t;
  typedef struct { bit start; bit abort; bit wv; bit hit; int base; int limit; } stim_t;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic check_outputs(input exp_t x);
    chk("state", 32'(state), 32'(x.st));
    chk("load_ready", 32'(load_ready), 32'(x.st == S_LOAD));
    chk("round_en", 32'(round_en), 32'(x.st == S_ROUND));
    chk("done", 32'(done), 32'((x.st == S_FOUND) || (x.st == S_EXHAUST)));
    chk("found", 32'(found), 32'(x.st == S_FOUND));
    chk("nonce", 32'(nonce), 32'(x.nonce));
    if (x.chk_rp) begin
      chk("round_idx", 32'(round_idx), 32'(x.ridx));
      chk("phase", 32'(phase), 32'(x.ph));
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st, input int n, input int r, input int p,
                              input bit c);
    exp_t x;
    x.st = st; x.nonce = n; x.ridx = r; x.ph = p; x.chk_rp = c;
    return x;
  endfunction

  function automatic stim_t noisy(input bit en, input bit allow_wv, input bit allow_start);
    stim_t s;
    s.abort = 1'b0;
    s.start = en && allow_start && ($urandom_range(0, 3) == 0);
    s.wv    = en && allow_wv && ($urandom_range(0, 2) == 0);
    s.hit   = en && ($urandom_range(0, 2) == 0);
    s.base  = int'($urandom_range(0, NMOD - 1));
    s.limit = int'($urandom_range(0, NMOD - 1));
    return s;
  endfunction

  task automatic apply(input stim_t s);
    start       = s.start;
    abort       = s.abort;
    word_valid  = s.wv;
    hash_hit    = s.hit;
    nonce_base  = NW'(s.base);
    nonce_limit = NW'(s.limit);
  endtask

  // Monitor: compare DUT outputs against the next expected entry after each edge
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check_outputs(x);
      end
    end
  end

  // Expand one job into stimulus/expectation traces, then drive it
  task automatic run_job(input int base, input int limit, input int hit_idx,
                         input int abort_mode, input bit noise);
    stim_t s_q[$];
    exp_t  e_q[$];
    int    nl[$];
    int    n, idx, last_j;
    stim_t s;
    logic [2:0] fin;

    n = base;
    for (int g = 0; g < NMOD + 1; g++) begin
      nl.push_back(n);
      if (n == limit) break;
      n = (n + 1) % NMOD;
    end
    if (hit_idx >= 0 && hit_idx < nl.size()) begin
      while (nl.size() > hit_idx + 1) void'(nl.pop_back());
    end else begin
      hit_idx = -1;
    end

    s = noisy(noise, 1'b0, 1'b0);
    s.start = 1'b1; s.base = base; s.limit = limit;
    s_q.push_back(s); e_q.push_back(mk(S_LOAD, base, 0, 0, 0));
    for (int w = 0; w < LW; w++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) begin
        s_q.push_back(noisy(noise, 1'b0, 1'b1)); e_q.push_back(mk(S_LOAD, base, 0, 0, 0));
      end
      s = noisy(noise, 1'b0, 1'b1);
      s.wv = 1'b1;
      s_q.push_back(s);
      e_q.push_back(mk((w == LW - 1) ? S_PREP : S_LOAD, base, 0, 0, 0));
    end

    last_j = nl.size() - 1;
    fin = S_EXHAUST;
    for (int j = 0; j <= last_j; j++) begin
      for (int i = 0; i < NR * RC; i++) begin
        s_q.push_back(noisy(noise, 1'b1, 1'b1));
        e_q.push_back(mk(S_ROUND, nl[j], i / RC, i % RC, 1));
      end
      s_q.push_back(noisy(noise, 1'b1, 1'b1)); e_q.push_back(mk(S_CHECK, nl[j], 0, 0, 0));
      s = noisy(noise, 1'b1, 1'b1);
      s.hit = (j == hit_idx);
      s_q.push_back(s);
      if (j == hit_idx) begin
        fin = S_FOUND;
        e_q.push_back(mk(S_FOUND, nl[j], 0, 0, 0));
      end else if (j == last_j) begin
        e_q.push_back(mk(S_EXHAUST, nl[j], 0, 0, 0));
      end else begin
        e_q.push_back(mk(S_NEXT, nl[j], 0, 0, 0));
        s_q.push_back(noisy(noise, 1'b1, 1'b1)); e_q.push_back(mk(S_PREP, nl[j + 1], 0, 0, 0));
      end
    end
    for (int k = 0; k < 2; k++) begin
      s_q.push_back(noisy(noise, 1'b1, 1'b0)); e_q.push_back(mk(fin, nl[last_j], 0, 0, 0));
    end

    idx = abort_mode;
    if (abort_mode == -2) begin
      idx = -1;
      foreach (e_q[k]) begin
        if (idx < 0 && e_q[k].st == S_ROUND && e_q[k].ridx == 2 && e_q[k].ph == 1) idx = k + 1;
      end
    end
    if (idx >= 1 && idx < e_q.size()) begin
      int held;
      held = e_q[idx - 1].nonce;
      while (e_q.size() > idx) begin
        void'(e_q.pop_back());
        void'(s_q.pop_back());
      end
      s = noisy(1'b1, 1'b1, 1'b1);
      s.abort = 1'b1;
      s_q.push_back(s); e_q.push_back(mk(S_IDLE, held, 0, 0, 1));
      s_q.push_back(noisy(1'b1, 1'b1, 1'b0)); e_q.push_back(mk(S_IDLE, held, 0, 0, 1));
    end

    foreach (s_q[k]) begin
      @(negedge clock);
      apply(s_q[k]);
      exp_q.push_back(e_q[k]);
    end
    @(negedge clock);
    apply(noisy(1'b0, 1'b0, 1'b0));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Asynchronous reset asserted mid-LOAD must clear outputs before the next edge
  task automatic reset_in_load();
    stim_t s;
    drain();
    s = noisy(1'b0, 1'b0, 1'b0);
    s.start = 1'b1; s.base = 9; s.limit = 9;
    @(negedge clock); apply(s); exp_q.push_back(mk(S_LOAD, 9, 0, 0, 0));
    s = noisy(1'b0, 1'b0, 1'b0);
    s.wv = 1'b1;
    @(negedge clock); apply(s); exp_q.push_back(mk(S_LOAD, 9, 0, 0, 0));
    @(negedge clock); apply(noisy(1'b0, 1'b0, 1'b0));
    #2 reset = 1'b1;
    #1 check_outputs(mk(S_IDLE, 0, 0, 0, 1));
    @(negedge clock); reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    apply(noisy(1'b0, 1'b0, 1'b0));
    #12 check_outputs(mk(S_IDLE, 0, 0, 0, 1));
    @(negedge clock); reset = 1'b0;

    run_job(5, 5, -1, -1, 1'b0);
    run_job(10, 20, 2, -1, 1'b1);
    run_job(30, 1, -1, -1, 1'b1);
    run_job(0, 3, -1, -2, 1'b1);
    run_job(7, 7, 0, -1, 1'b1);
    reset_in_load();
    run_job(31, 31, -1, -1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      int b, span, hit, ab;
      b    = int'($urandom_range(0, NMOD - 1));
      span = int'($urandom_range(0, 3));
      hit  = int'($urandom_range(0, 4)) - 1;
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
      run_job(b, (b + span) % NMOD, hit, ab, 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
